// File: rtl/dijkstra_pkg.sv
// Shared types and sizing for the Dijkstra path extractor slice.
package dijkstra_pkg;

  localparam int MAX_NODES        = 128;
  localparam int NODE_W           = $clog2(MAX_NODES);
  localparam int PRED_INVALID_BIT = NODE_W;

  typedef logic [NODE_W-1:0] node_t;
  typedef logic [NODE_W:0]   count_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    EMIT,
    FINISH
  } extractor_state_t;

endpackage

// File: rtl/dijkstra_path_extractor_path_stack.sv
// LIFO of node indices visited on the backward walk; top is read combinationally.
module path_stack
  import dijkstra_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  node_t  din,
  output node_t  top,
  output count_t depth
);

  localparam count_t DEPTH_MAX = count_t'(MAX_NODES);

  node_t  mem [MAX_NODES];
  count_t depth_q;
  count_t depth_d;
  node_t  top_idx;
  logic   do_push;
  logic   do_pop;

  assign do_push = push && (depth_q != DEPTH_MAX);
  assign do_pop  = pop && (depth_q != '0);
  assign top_idx = node_t'(depth_q - count_t'(1));
  assign top     = mem[top_idx];
  assign depth   = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (clear) begin
      depth_d = '0;
    end else if (do_push) begin
      depth_d = depth_q + count_t'(1);
    end else if (do_pop) begin
      depth_d = depth_q - count_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Storage needs no reset: entries above depth are never observed.
  always_ff @(posedge clock) begin
    if (do_push && !clear) begin
      mem[depth_q[NODE_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/dijkstra_path_extractor.sv
// Walks the predecessor table from dest back to src, then streams the path src->dest.
module dijkstra_path_extractor
  import dijkstra_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [NODE_W-1:0] src,
  input  logic [NODE_W-1:0] dest,
  input  logic [NODE_W:0]   num_nodes,
  output logic [NODE_W-1:0] pred_rd_addr,
  input  logic [NODE_W:0]   pred_rd_data,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [NODE_W:0]   path_len,
  output logic          path_valid,
  output logic [NODE_W-1:0] path_node,
  output logic          path_last,
  input  logic          path_ready
);

  localparam count_t LEN_MAX = count_t'(MAX_NODES);

  extractor_state_t state_q, state_d;
  node_t  cur_q, cur_d;
  node_t  src_q, src_d;
  count_t num_q, num_d;
  count_t path_len_q, path_len_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   error_q, error_d;

  logic   stk_push;
  logic   stk_pop;
  logic   stk_clear;
  node_t  stk_top;
  count_t stk_depth;

  path_stack u_stack (
    .clock (clock),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .clear (stk_clear),
    .din   (cur_q),
    .top   (stk_top),
    .depth (stk_depth)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    src_d      = src_q;
    num_d      = num_q;
    path_len_d = path_len_q;
    busy_d     = busy_q;
    error_d    = error_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_clear  = (state_q == FINISH);

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d      = src;
          num_d      = num_nodes;
          cur_d      = dest;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          path_len_d = '0;
          if (({1'b0, src} >= num_nodes) || ({1'b0, dest} >= num_nodes)) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        stk_push = 1'b1;
        if (path_len_q != LEN_MAX) begin
          path_len_d = path_len_q + count_t'(1);
        end
        state_d = (cur_q == src_q) ? EMIT : DATA;
      end
      DATA: begin
        // A full stack without reaching src means the table contains a cycle.
        if (pred_rd_data[PRED_INVALID_BIT] || (stk_depth == num_q)) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          cur_d   = pred_rd_data[NODE_W-1:0];
          state_d = ADDR;
        end
      end
      EMIT: begin
        if (path_ready) begin
          stk_pop = 1'b1;
          if (stk_depth == count_t'(1)) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      src_q      <= '0;
      num_q      <= '0;
      path_len_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      src_q      <= src_d;
      num_q      <= num_d;
      path_len_q <= path_len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Stream outputs are gated so stale stack contents never leak out.
  assign path_valid   = (state_q == EMIT);
  assign path_node    = path_valid ? stk_top : '0;
  assign path_last    = path_valid && (stk_depth == count_t'(1));
  assign pred_rd_addr = cur_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign path_len     = path_len_q;

endmodule

// File: tb/tb_dijkstra_path_extractor.sv
// Directed self-checking bench for dijkstra_path_extractor with a behavioural predecessor table.
module tb_dijkstra_path_extractor;

  logic       clock;
  logic       reset;
  logic       start;
  logic [6:0] src;
  logic [6:0] dest;
  logic [7:0] num_nodes;
  logic [6:0] pred_rd_addr;
  logic [7:0] pred_rd_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] path_len;
  logic       path_valid;
  logic [6:0] path_node;
  logic       path_last;
  logic       path_ready;

  logic [7:0] pred_mem [128];

  int errors;
  int checks;

  logic [6:0] bnode [16];
  logic       blast [16];
  int         nb;
  int         first_cyc;
  int         done_cyc;
  int         valid_cnt;
  int         stall_bad;
  bit         saw_done;
  logic       got_err;
  logic [7:0] got_len;

  dijkstra_path_extractor dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .src          (src),
    .dest         (dest),
    .num_nodes    (num_nodes),
    .pred_rd_addr (pred_rd_addr),
    .pred_rd_data (pred_rd_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .path_len     (path_len),
    .path_valid   (path_valid),
    .path_node    (path_node),
    .path_last    (path_last),
    .path_ready   (path_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous table read: data valid one cycle after the address.
  always @(posedge clock) begin
    pred_rd_data <= pred_mem[pred_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearTable();
    for (int i = 0; i < 128; i++) pred_mem[i] = 8'h80;
  endtask

  // Called just after a negedge; start is dropped by runCollect on the next negedge.
  task automatic applyStimulus(input logic [6:0] s, input logic [6:0] d, input logic [7:0] n);
    src       = s;
    dest      = d;
    num_nodes = n;
    start     = 1'b1;
  endtask

  task automatic runCollect(input logic [3:0] ready_pat, input int max_cyc,
                            input int restart_cyc, input int stop_after_beats);
    logic       last_v;
    logic       last_r;
    logic [6:0] last_n;
    nb = 0; first_cyc = 0; done_cyc = 0; valid_cnt = 0; stall_bad = 0;
    saw_done = 0; got_err = 1'b0; got_len = '0;
    last_v = 1'b0; last_r = 1'b0; last_n = '0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clock);
      if (cyc == 1) start = 1'b0;
      if (cyc == restart_cyc) begin
        start = 1'b1; src = 7'd1; dest = 7'd6; num_nodes = 8'd8;
      end else if (restart_cyc > 0 && cyc == restart_cyc + 1) begin
        start = 1'b0;
      end
      path_ready = ready_pat[(cyc - 1) % 4];
      if (last_v && !last_r && (path_node !== last_n)) stall_bad++;
      if (path_valid) begin
        valid_cnt++;
        if (first_cyc == 0) first_cyc = cyc;
      end
      if (path_valid && path_ready) begin
        if (nb < 16) begin
          bnode[nb] = path_node;
          blast[nb] = path_last;
        end
        nb++;
      end
      last_v = path_valid; last_r = path_ready; last_n = path_node;
      if (done) begin
        saw_done = 1; done_cyc = cyc; got_err = error; got_len = path_len;
        break;
      end
      if (stop_after_beats > 0 && nb >= stop_after_beats) break;
    end
  endtask

  task automatic checkPath5(input string tag);
    logic [6:0] exp_path [4];
    exp_path = '{7'd0, 7'd1, 7'd3, 7'd5};
    checkOutput({tag, "_done"}, 32'(saw_done), 32'd1);
    checkOutput({tag, "_err"}, 32'(got_err), 32'd0);
    checkOutput({tag, "_len"}, 32'(got_len), 32'd4);
    checkOutput({tag, "_beats"}, 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_node%0d", tag, i), 32'(bnode[i]), 32'(exp_path[i]));
      checkOutput($sformatf("%s_last%0d", tag, i), 32'(blast[i]), (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic idleGap();
    path_ready = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; start = 1'b0; src = '0; dest = '0; num_nodes = '0; path_ready = 1'b1;
    clearTable();
    repeat (2) @(negedge clock);
    checkOutput("reset_outs", 32'({busy, done, error, path_len, path_valid, path_node, path_last, pred_rd_addr}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] single node path");
    pred_mem[0] = 8'h00;
    applyStimulus(7'd0, 7'd0, 8'd8);
    runCollect(4'b1111, 50, 0, 0);
    checkOutput("t1_done", 32'(saw_done), 32'd1);
    checkOutput("t1_err", 32'(got_err), 32'd0);
    checkOutput("t1_len", 32'(got_len), 32'd1);
    checkOutput("t1_beats", 32'(nb), 32'd1);
    checkOutput("t1_node", 32'(bnode[0]), 32'd0);
    checkOutput("t1_last", 32'(blast[0]), 32'd1);
    checkOutput("t1_first_cyc", 32'(first_cyc), 32'd2);
    checkOutput("t1_done_cyc", 32'(done_cyc), 32'd3);
    idleGap();
    checkOutput("t1_busy_after", 32'(busy), 32'd0);

    $display("[TB] four node path");
    pred_mem[5] = 8'd3; pred_mem[3] = 8'd1; pred_mem[1] = 8'd0;
    applyStimulus(7'd0, 7'd5, 8'd8);
    runCollect(4'b1111, 100, 0, 0);
    checkPath5("t2");
    idleGap();

    $display("[TB] four node path with backpressure");
    applyStimulus(7'd0, 7'd5, 8'd8);
    runCollect(4'b1001, 100, 0, 0);
    checkPath5("t3");
    checkOutput("t3_stall_stable", 32'(stall_bad), 32'd0);
    idleGap();

    $display("[TB] unreachable destination");
    applyStimulus(7'd0, 7'd4, 8'd8);
    runCollect(4'b1111, 100, 0, 0);
    checkOutput("t4_done", 32'(saw_done), 32'd1);
    checkOutput("t4_err", 32'(got_err), 32'd1);
    checkOutput("t4_valid_cnt", 32'(valid_cnt), 32'd0);
    idleGap();

    $display("[TB] predecessor loop");
    pred_mem[2] = 8'd3; pred_mem[3] = 8'd2;
    applyStimulus(7'd0, 7'd2, 8'd4);
    runCollect(4'b1111, 100, 0, 0);
    checkOutput("t5_done", 32'(saw_done), 32'd1);
    checkOutput("t5_err", 32'(got_err), 32'd1);
    checkOutput("t5_len", 32'(got_len), 32'd4);
    checkOutput("t5_valid_cnt", 32'(valid_cnt), 32'd0);
    idleGap();
    pred_mem[3] = 8'd1;

    $display("[TB] operand out of range");
    applyStimulus(7'd0, 7'd9, 8'd8);
    runCollect(4'b1111, 2, 0, 0);
    checkOutput("t6_done", 32'(saw_done), 32'd1);
    checkOutput("t6_err", 32'(got_err), 32'd1);
    checkOutput("t6_valid_cnt", 32'(valid_cnt), 32'd0);
    idleGap();
    checkOutput("t6_err_held", 32'(error), 32'd1);

    $display("[TB] reset during stream");
    applyStimulus(7'd0, 7'd5, 8'd8);
    runCollect(4'b1111, 100, 0, 1);
    checkOutput("t7_beats_before", 32'(nb), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t7_reset_outs", 32'({busy, done, error, path_len, path_valid, path_node, path_last, pred_rd_addr}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    applyStimulus(7'd0, 7'd5, 8'd8);
    runCollect(4'b1111, 100, 0, 0);
    checkPath5("t7");
    idleGap();

    $display("[TB] start pulsed while busy");
    applyStimulus(7'd0, 7'd5, 8'd8);
    runCollect(4'b1111, 100, 2, 0);
    checkPath5("t8");
    idleGap();
    checkOutput("t8_idle_after", 32'({busy, path_valid}), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
